// File: rtl/prog_loader_pkg.sv
// Shared types and header-field layout for the instruction-memory loader.
// Header word layout: [ADDR_W-1:0] start address, [2*ADDR_W-1:ADDR_W] word count.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    localparam int unsigned HDR_START_LSB = 0;

    function automatic int unsigned hdr_start_msb(input int unsigned addr_w);
        return addr_w - 1;
    endfunction

    function automatic int unsigned hdr_cnt_lsb(input int unsigned addr_w);
        return addr_w;
    endfunction

    function automatic int unsigned hdr_cnt_msb(input int unsigned addr_w);
        return (2 * addr_w) - 1;
    endfunction

    // Both header fields must fit inside one stream word.
    function automatic bit widths_ok(input int unsigned data_w, input int unsigned addr_w);
        return data_w >= (2 * addr_w);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams a segmented, checksummed program image into instruction memory and
// holds the CPU in reset-like idle (cpu_en low) until the image loads cleanly.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              w_enable,
    output logic [ADDR_W-1:0] w_adrs,
    output logic [DATA_W-1:0] w_instruction,
    output logic              cpu_en,
    output logic              busy,
    output logic              error,
    output logic [CNT_W-1:0]  words_loaded
);

    localparam int unsigned START_LSB = HDR_START_LSB;
    localparam int unsigned START_MSB = hdr_start_msb(ADDR_W);
    localparam int unsigned CNT_LSB   = hdr_cnt_lsb(ADDR_W);
    localparam int unsigned CNT_MSB   = hdr_cnt_msb(ADDR_W);
    localparam int unsigned AW1       = ADDR_W + 1;
    localparam logic [AW1-1:0] MEM_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    if (!widths_ok(DATA_W, ADDR_W)) begin : g_width_check
        $error("prog_loader: DATA_W must be at least 2*ADDR_W");
    end

    state_e state_q, state_d;

    logic              hs;
    logic [ADDR_W-1:0] hdr_start;
    logic [ADDR_W-1:0] hdr_count;
    logic [AW1-1:0]    hdr_end;
    logic              hdr_range_err;
    logic              last_word;
    logic              csum_match;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [DATA_W-1:0] csum_q, csum_d;

    logic              s_ready_q, s_ready_d;
    logic              w_enable_q, w_enable_d;
    logic [ADDR_W-1:0] w_adrs_q, w_adrs_d;
    logic [DATA_W-1:0] w_instruction_q, w_instruction_d;
    logic              cpu_en_q, cpu_en_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  words_loaded_q, words_loaded_d;

    // s_ready_q is purely a function of state, so it doubles as the accept qualifier.
    assign hs            = s_valid && s_ready_q;
    assign hdr_start     = s_data[START_MSB:START_LSB];
    assign hdr_count     = s_data[CNT_MSB:CNT_LSB];
    assign hdr_end       = AW1'(hdr_start) + AW1'(hdr_count);
    assign hdr_range_err = hdr_end > MEM_DEPTH;
    assign last_word     = remaining_q == ADDR_W'(1);
    assign csum_match    = s_data == csum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // load_req wins over any handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        if (load_req) begin
            state_d = ST_HDR;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_HDR: begin
                    if (hs) begin
                        if (hdr_count == '0) begin
                            state_d = ST_RUN;
                        end else if (hdr_range_err) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (hs && last_word) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (hs) begin
                        state_d = csum_match ? ST_HDR : ST_ERR;
                    end
                end
                ST_RUN:  state_d = ST_RUN;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        csum_d          = csum_q;
        w_enable_d      = 1'b0;
        w_adrs_d        = w_adrs_q;
        w_instruction_d = w_instruction_q;
        words_loaded_d  = words_loaded_q;

        // Status flags follow the next state so they land with the transition.
        s_ready_d = state_d inside {ST_HDR, ST_DATA, ST_CSUM};
        busy_d    = state_d inside {ST_HDR, ST_DATA, ST_CSUM};
        cpu_en_d  = state_d == ST_RUN;
        error_d   = state_d == ST_ERR;

        if (load_req) begin
            addr_d         = '0;
            remaining_d    = '0;
            csum_d         = '0;
            words_loaded_d = '0;
        end else if (hs) begin
            case (state_q)
                ST_HDR: begin
                    addr_d      = hdr_start;
                    remaining_d = hdr_count;
                    csum_d      = '0;
                end
                ST_DATA: begin
                    w_enable_d      = 1'b1;
                    w_adrs_d        = addr_q;
                    w_instruction_d = s_data;
                    csum_d          = csum_q + s_data;
                    addr_d          = addr_q + ADDR_W'(1);
                    remaining_d     = remaining_q - ADDR_W'(1);
                    if (words_loaded_q != '1) begin
                        words_loaded_d = words_loaded_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q          <= '0;
            remaining_q     <= '0;
            csum_q          <= '0;
            s_ready_q       <= 1'b0;
            w_enable_q      <= 1'b0;
            w_adrs_q        <= '0;
            w_instruction_q <= '0;
            cpu_en_q        <= 1'b0;
            busy_q          <= 1'b0;
            error_q         <= 1'b0;
            words_loaded_q  <= '0;
        end else begin
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            csum_q          <= csum_d;
            s_ready_q       <= s_ready_d;
            w_enable_q      <= w_enable_d;
            w_adrs_q        <= w_adrs_d;
            w_instruction_q <= w_instruction_d;
            cpu_en_q        <= cpu_en_d;
            busy_q          <= busy_d;
            error_q         <= error_d;
            words_loaded_q  <= words_loaded_d;
        end
    end

    assign s_ready       = s_ready_q;
    assign w_enable      = w_enable_q;
    assign w_adrs        = w_adrs_q;
    assign w_instruction = w_instruction_q;
    assign cpu_en        = cpu_en_q;
    assign busy          = busy_q;
    assign error         = error_q;
    assign words_loaded  = words_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: header range table, directed corner
// sequences, and random images compared against an image-level reference model.
module tb_prog_loader;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned CNT_W  = 4;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_req;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              w_enable;
    logic [ADDR_W-1:0] w_adrs;
    logic [DATA_W-1:0] w_instruction;
    logic              cpu_en;
    logic              busy;
    logic              error;
    logic [CNT_W-1:0]  words_loaded;

    prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .w_enable     (w_enable),
        .w_adrs       (w_adrs),
        .w_instruction(w_instruction),
        .cpu_en       (cpu_en),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    typedef struct {
        logic [10:0] start;
        logic [10:0] cnt;
        logic        exp_err;
        logic        exp_run;
        logic        exp_busy;
    } hdr_vec_t;

    int errors = 0;
    int checks = 0;
    bit acc_ok;

    wr_t         wq[$];
    wr_t         exp_q[$];
    logic [31:0] img_q[$];
    int          m_acc;
    bit          m_err;
    bit          m_run;

    // Collect every write strobe seen on the memory port.
    always @(posedge clk) begin
        #1;
        if (w_enable === 1'b1) begin
            wq.push_back('{adr: 32'(w_adrs), dat: w_instruction});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one word; returns at the negedge after acceptance, or ok=0 if never ready.
    task automatic send_word(input logic [31:0] w, input int gap, output bit ok);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_data  = w;
        s_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 4 && !ok; t++) begin
            if (s_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        wq.delete();
    endtask

    function automatic logic [31:0] mk_hdr(input int start, input int cnt);
        return 32'((cnt << ADDR_W) | start);
    endfunction

    // Walks the image by the format rules: returns expected writes and final status.
    function automatic void run_model();
        int i;
        int start;
        int cnt;
        logic [31:0] hdr;
        logic [31:0] sum;
        bit done;
        exp_q.delete();
        m_err = 1'b0;
        m_run = 1'b0;
        i = 0;
        done = 1'b0;
        while (!done && i < img_q.size()) begin
            hdr = img_q[i];
            i++;
            start = int'(hdr[10:0]);
            cnt   = int'(hdr[21:11]);
            if (cnt == 0) begin
                m_run = 1'b1;
                done = 1'b1;
            end else if (start + cnt > DEPTH) begin
                m_err = 1'b1;
                done = 1'b1;
            end else begin
                sum = 32'd0;
                for (int k = 0; k < cnt; k++) begin
                    exp_q.push_back('{adr: 32'(start + k), dat: img_q[i]});
                    sum += img_q[i];
                    i++;
                end
                if (img_q[i] != sum) begin
                    m_err = 1'b1;
                    done = 1'b1;
                end
                i++;
            end
        end
        m_acc = i;
    endfunction

    hdr_vec_t hv[8];

    initial begin
        hv[0] = '{start: 11'h7FF, cnt: 11'd2,     exp_err: 1'b1, exp_run: 1'b0, exp_busy: 1'b0};
        hv[1] = '{start: 11'h7FF, cnt: 11'd1,     exp_err: 1'b0, exp_run: 1'b0, exp_busy: 1'b1};
        hv[2] = '{start: 11'h000, cnt: 11'd0,     exp_err: 1'b0, exp_run: 1'b1, exp_busy: 1'b0};
        hv[3] = '{start: 11'h001, cnt: 11'h7FF,   exp_err: 1'b0, exp_run: 1'b0, exp_busy: 1'b1};
        hv[4] = '{start: 11'h002, cnt: 11'h7FF,   exp_err: 1'b1, exp_run: 1'b0, exp_busy: 1'b0};
        hv[5] = '{start: 11'h400, cnt: 11'h400,   exp_err: 1'b0, exp_run: 1'b0, exp_busy: 1'b1};
        hv[6] = '{start: 11'h401, cnt: 11'h400,   exp_err: 1'b1, exp_run: 1'b0, exp_busy: 1'b0};
        hv[7] = '{start: 11'h000, cnt: 11'h7FF,   exp_err: 1'b0, exp_run: 1'b0, exp_busy: 1'b1};

        reset = 1'b1;
        load_req = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_w_enable", 32'(w_enable), 32'd0);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", 32'(s_ready), 32'd0);

        // Nominal two-segment image.
        pulse_load();
        chk("ld_busy", 32'(busy), 32'd1);
        chk("ld_cpu_en", 32'(cpu_en), 32'd0);
        send_word(mk_hdr(0, 2), 0, acc_ok);
        send_word(32'h0000000E, 0, acc_ok);
        chk("nom_we0", 32'(w_enable), 32'd1);
        chk("nom_adr0", 32'(w_adrs), 32'h000);
        chk("nom_dat0", w_instruction, 32'h0000000E);
        send_word(32'h0000000F, 0, acc_ok);
        chk("nom_adr1", 32'(w_adrs), 32'h001);
        chk("nom_dat1", w_instruction, 32'h0000000F);
        send_word(32'h0000001D, 0, acc_ok);
        chk("nom_csum_we", 32'(w_enable), 32'd0);
        send_word(mk_hdr(32'h0FF, 1), 0, acc_ok);
        send_word(32'hFFFFFFFF, 0, acc_ok);
        chk("nom_adr2", 32'(w_adrs), 32'h0FF);
        chk("nom_dat2", w_instruction, 32'hFFFFFFFF);
        send_word(32'hFFFFFFFF, 0, acc_ok);
        send_word(32'h0, 0, acc_ok);
        chk("nom_cpu_en", 32'(cpu_en), 32'd1);
        chk("nom_busy", 32'(busy), 32'd0);
        chk("nom_error", 32'(error), 32'd0);
        chk("nom_words", 32'(words_loaded), 32'd3);
        chk("nom_wcount", 32'(wq.size()), 32'd3);

        // Reload from RUN.
        pulse_load();
        chk("rl_cpu_en", 32'(cpu_en), 32'd0);
        chk("rl_words", 32'(words_loaded), 32'd0);
        chk("rl_busy", 32'(busy), 32'd1);

        // Bad checksum.
        send_word(mk_hdr(4, 1), 0, acc_ok);
        send_word(32'hE0000000, 0, acc_ok);
        chk("bad_adr", 32'(w_adrs), 32'h004);
        send_word(32'h0, 0, acc_ok);
        chk("bad_error", 32'(error), 32'd1);
        chk("bad_cpu_en", 32'(cpu_en), 32'd0);
        send_word(32'h0, 0, acc_ok);
        chk("bad_no_accept", 32'(acc_ok), 32'd0);

        // Header range table.
        for (int v = 0; v < 8; v++) begin
            pulse_load();
            send_word(mk_hdr(int'(hv[v].start), int'(hv[v].cnt)), 0, acc_ok);
            chk($sformatf("hdr%0d_error", v), 32'(error), 32'(hv[v].exp_err));
            chk($sformatf("hdr%0d_cpu_en", v), 32'(cpu_en), 32'(hv[v].exp_run));
            chk($sformatf("hdr%0d_busy", v), 32'(busy), 32'(hv[v].exp_busy));
            chk($sformatf("hdr%0d_nowrite", v), 32'(wq.size()), 32'd0);
        end

        // Range error then legal top-of-memory segment.
        pulse_load();
        send_word(mk_hdr(32'h7FF, 2), 0, acc_ok);
        chk("rng_error", 32'(error), 32'd1);
        pulse_load();
        chk("rng_clr_error", 32'(error), 32'd0);
        send_word(mk_hdr(32'h7FF, 1), 0, acc_ok);
        send_word(32'h12345678, 0, acc_ok);
        chk("rng_we", 32'(w_enable), 32'd1);
        chk("rng_adr", 32'(w_adrs), 32'h7FF);
        chk("rng_dat", w_instruction, 32'h12345678);

        // Backpressure gaps inside a segment.
        pulse_load();
        send_word(mk_hdr(32'h010, 3), 0, acc_ok);
        send_word(32'h11, 0, acc_ok);
        send_word(32'h22, 2, acc_ok);
        send_word(32'h33, 1, acc_ok);
        send_word(32'h66, 1, acc_ok);
        send_word(32'h0, 0, acc_ok);
        chk("bp_wcount", 32'(wq.size()), 32'd3);
        for (int k = 0; k < 3 && k < wq.size(); k++) begin
            chk($sformatf("bp_adr%0d", k), wq[k].adr, 32'(32'h010 + k));
            chk($sformatf("bp_dat%0d", k), wq[k].dat, 32'(32'h11 * (k + 1)));
        end
        chk("bp_cpu_en", 32'(cpu_en), 32'd1);
        chk("bp_error", 32'(error), 32'd0);

        // Saturation of words_loaded.
        pulse_load();
        send_word(mk_hdr(32'h200, 20), 0, acc_ok);
        for (int k = 1; k <= 20; k++) send_word(32'(k), 0, acc_ok);
        chk("sat_words", 32'(words_loaded), 32'(CNT_MAX));
        send_word(32'd210, 0, acc_ok);
        send_word(32'h0, 0, acc_ok);
        chk("sat_cpu_en", 32'(cpu_en), 32'd1);

        // load_req coincident with a DATA handshake.
        pulse_load();
        send_word(mk_hdr(32'h020, 2), 0, acc_ok);
        send_word(32'h0000AAAA, 0, acc_ok);
        s_data = 32'h0000BBBB;
        s_valid = 1'b1;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        s_valid = 1'b0;
        chk("pri_we", 32'(w_enable), 32'd0);
        chk("pri_words", 32'(words_loaded), 32'd0);
        chk("pri_busy", 32'(busy), 32'd1);
        chk("pri_s_ready", 32'(s_ready), 32'd1);
        send_word(32'h0, 0, acc_ok);
        chk("pri_cpu_en", 32'(cpu_en), 32'd1);

        // Asynchronous reset while a write strobe is active.
        pulse_load();
        send_word(mk_hdr(32'h030, 4), 0, acc_ok);
        send_word(32'h55, 0, acc_ok);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_s_ready", 32'(s_ready), 32'd0);
        chk("ar_w_enable", 32'(w_enable), 32'd0);
        chk("ar_w_adrs", 32'(w_adrs), 32'd0);
        chk("ar_w_instr", w_instruction, 32'd0);
        chk("ar_cpu_en", 32'(cpu_en), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_error", 32'(error), 32'd0);
        chk("ar_words", 32'(words_loaded), 32'd0);
        @(negedge clk);
        @(negedge clk);
        wq.delete();
        reset = 1'b0;
        s_data = 32'h66;
        s_valid = 1'b1;
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        chk("ar_nowrite", 32'(wq.size()), 32'd0);
        chk("ar_idle_ready", 32'(s_ready), 32'd0);

        // Random images against the reference model.
        for (int it = 0; it < 40; it++) begin
            int nseg;
            int acc;
            img_q.delete();
            nseg = $urandom_range(1, 3);
            for (int s = 0; s < nseg; s++) begin
                int mode;
                int cnt;
                int start;
                logic [31:0] sum;
                logic [31:0] w;
                mode  = $urandom_range(0, 7);
                cnt   = $urandom_range(1, 4);
                start = (mode == 0) ? DEPTH - int'($urandom_range(1, 5))
                                    : int'($urandom_range(0, DEPTH - 1));
                img_q.push_back(($urandom & 32'hFFC0_0000) | mk_hdr(start, cnt));
                sum = 32'd0;
                for (int k = 0; k < cnt; k++) begin
                    w = $urandom;
                    img_q.push_back(w);
                    sum += w;
                end
                img_q.push_back((mode == 1) ? sum + 32'd1 : sum);
            end
            img_q.push_back($urandom & 32'hFFC0_0000);
            run_model();

            pulse_load();
            acc = 0;
            for (int j = 0; j < img_q.size(); j++) begin
                send_word(img_q[j], $urandom_range(0, 2), acc_ok);
                if (!acc_ok) break;
                acc++;
            end
            repeat (2) @(negedge clk);
            chk($sformatf("rnd%0d_accepted", it), 32'(acc), 32'(m_acc));
            chk($sformatf("rnd%0d_wcount", it), 32'(wq.size()), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < wq.size(); k++) begin
                chk($sformatf("rnd%0d_adr%0d", it, k), wq[k].adr, exp_q[k].adr);
                chk($sformatf("rnd%0d_dat%0d", it, k), wq[k].dat, exp_q[k].dat);
            end
            chk($sformatf("rnd%0d_error", it), 32'(error), 32'(m_err));
            chk($sformatf("rnd%0d_cpu_en", it), 32'(cpu_en), 32'(m_run));
            chk($sformatf("rnd%0d_busy", it), 32'(busy), 32'd0);
            chk($sformatf("rnd%0d_words", it), 32'(words_loaded),
                32'((exp_q.size() > CNT_MAX) ? CNT_MAX : exp_q.size()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised instruction-memory loader in front of the pipelined CPU top level. It accepts a segmented program image over a valid/ready word stream. It writes each payload word into instruction memory through the existing `w_enable`/`w_adrs`/`w_instruction` port, verifies a per-segment additive checksum, and holds `cpu_en` low until the whole image is loaded cleanly. It replaces hand-sequenced memory writes with a self-checking, restartable load that can target multiple non-contiguous regions.

## Interface
- `DATA_W`, 32: instruction/stream word width; must be ≥ 2*ADDR_W.
- `ADDR_W`, 11: instruction memory address width; memory depth is 2^ADDR_W words.
- `CNT_W`, 16: width of `words_loaded`.

- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `load_req` in 1: one-cycle pulse; starts or restarts a load.
- `s_valid` in 1: stream word valid.
- `s_ready` out 1: loader can accept a word.
- `s_data` in DATA_W: stream word.
- `w_enable` out 1: instruction memory write strobe.
- `w_adrs` out ADDR_W: write address.
- `w_instruction` out DATA_W: write data.
- `cpu_en` out 1: CPU run enable.
- `busy` out 1: a load is in progress (state HDR, DATA or CSUM).
- `error` out 1: sticky load error.
- `words_loaded` out CNT_W: payload words written since the last `load_req`; saturates at all-ones.

## Operation
- Image format: one or more segments, then a terminator.
  - Segment: header, then `count` payload words, then a checksum word.
  - Header fields: `s_data[ADDR_W-1:0]` = start address; `s_data[2*ADDR_W-1:ADDR_W]` = count. Upper header bits are ignored.
  - Terminator: a header with count = 0.
  - Checksum = sum of the segment's payload words, mod 2^DATA_W.
- FSM states: IDLE, HDR, DATA, CSUM, RUN, ERR.
- IDLE: `cpu_en`=0, `s_ready`=0. `load_req` → HDR.
- HDR: `s_ready`=1. On handshake:
  - count = 0 → RUN.
  - start + count > 2^ADDR_W (evaluated at ADDR_W+1 bits) → ERR. No write occurs.
  - Otherwise: latch address = start, remaining = count, clear the checksum accumulator → DATA.
- DATA: `s_ready`=1. Each handshake writes `s_data` to the current address, adds it to the accumulator, increments the address and decrements remaining. The last word → CSUM.
- CSUM: `s_ready`=1. On handshake:
  - match → HDR.
  - mismatch → ERR.
- RUN: `cpu_en`=1, `s_ready`=0. `load_req` → HDR and drops `cpu_en` (reload).
- ERR: `cpu_en`=0, `s_ready`=0, `error`=1.
  - Only `load_req` or `reset` leaves ERR. `load_req` → HDR.
  - Words already written stay in memory.
- `load_req` in any state → HDR. It clears `error`, `words_loaded`, the accumulator and any partial segment. A `load_req` in the same cycle as a stream handshake takes priority; that word is discarded, not consumed.
- The address never wraps within a segment; the range check at HDR guarantees this.
- Segments may overlap. A later write to an address overwrites an earlier one.

## Timing
- Reset values: state IDLE; `s_ready`, `w_enable`, `cpu_en`, `busy`, `error` = 0; `w_adrs`, `w_instruction`, `words_loaded` = 0.
- All outputs are registered.
- `s_ready` is a registered function of state. Asserting it does not depend on `s_valid`.
- Write latency: a payload handshake in cycle N gives `w_enable`=1 in cycle N+1, with that word's address and data. `w_enable` is high for exactly one cycle per payload word. Back-to-back handshakes give back-to-back writes.
- `words_loaded` updates in the same cycle as `w_enable`.
- Terminator handshake in cycle N: `cpu_en`=1 and `busy`=0 from cycle N+1.
- `load_req` in cycle N: `cpu_en`=0, `busy`=1 and `error`=0 from cycle N+1.
- Checksum mismatch or range error at handshake cycle N: `error`=1 from N+1.
- `s_valid` low stalls the FSM with no write and no state change.
- Reset mid-load aborts immediately (asynchronous) and returns to IDLE. Memory contents are undefined from the loader's point of view.

## Structure
- Shared package `prog_loader_pkg` holds:
  - the state enum;
  - header field localparams (start LSB/MSB, count LSB/MSB) as functions of ADDR_W;
  - the `DATA_W >= 2*ADDR_W` elaboration check.
- Single module, no sub-module. The checksum accumulator and address counter are inline registers.

## Test plan
- Nominal image: seg{start 0x000, count 2, 0x0000000E, 0x0000000F, csum 0x0000001D}, seg{start 0x0FF, count 1, 0xFFFFFFFF, csum 0xFFFFFFFF}, terminator → three writes at addresses 0x000, 0x001, 0x0FF with matching data; `words_loaded`=3; `cpu_en`=1 the cycle after the terminator; `error`=0.
- Bad checksum: seg{start 0x004, count 1, 0xE0000000, csum 0x00000000} → one write at 0x004; `error`=1; `cpu_en` stays 0; subsequent `s_valid` words are not accepted.
- Range error: header start 0x7FF, count 2 → no write; `error`=1. Start 0x7FF, count 1 after `load_req` → accepted, write at 0x7FF.
- Backpressure gaps: `s_valid` toggled 1,0,0,1 during DATA → exactly one `w_enable` per accepted word, addresses contiguous, checksum unaffected.
- Reload and priority: from RUN, pulse `load_req` → `cpu_en` falls next cycle, `words_loaded`=0. `load_req` coincident with a DATA handshake → that word is not written; state is HDR.
- Asynchronous reset mid-DATA → all outputs at reset values immediately; no further writes until a new `load_req`.
